mem_stage: RTL

Memory-access stage of the five-stage pipeline, downstream of the execute ALU. It consumes the ALU result as a byte address, performs loads and stores against an internal word-addressed data memory with a configurable multi-cycle access latency, and drives `freeze` to stall the upstream stages while an access is in flight. It also owns the MEM/WB pipeline register that feeds write-back.

---
 rtl/mem_stage_if.sv | 46 ++++
 rtl/mem_stage.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/mem_stage_if.sv
// Purpose: bundles the EX/MEM request fields and the MEM/WB result fields of mem_stage.
// Latency: none; this is wiring only.
// Backpressure: freeze travels back to the producer of the request fields.
//
// master modport: upstream side (drives requests, observes freeze and MEM/WB fields).
// slave  modport: mem_stage itself.
// mem_err_out exists only when MEM_ERR_CHECK_EN is defined.
interface mem_stage_if;
    // EX/MEM request fields
    logic        mem_r_en;
    logic        mem_w_en;
    logic        wb_en;
    logic [4:0]  dest;
    logic [31:0] ALU_result;
    logic [31:0] st_val;
    // stall and MEM/WB fields
    logic        freeze;
    logic        wb_en_out;
    logic        mem_r_en_out;
    logic [4:0]  dest_out;
    logic [31:0] ALU_result_out;
    logic [31:0] mem_result;
`ifdef MEM_ERR_CHECK_EN
    logic        mem_err_out;

    modport master (
        output mem_r_en, mem_w_en, wb_en, dest, ALU_result, st_val,
        input  freeze, wb_en_out, mem_r_en_out, dest_out, ALU_result_out, mem_result,
        input  mem_err_out
    );
    modport slave (
        input  mem_r_en, mem_w_en, wb_en, dest, ALU_result, st_val,
        output freeze, wb_en_out, mem_r_en_out, dest_out, ALU_result_out, mem_result,
        output mem_err_out
    );
`else
    modport master (
        output mem_r_en, mem_w_en, wb_en, dest, ALU_result, st_val,
        input  freeze, wb_en_out, mem_r_en_out, dest_out, ALU_result_out, mem_result
    );
    modport slave (
        input  mem_r_en, mem_w_en, wb_en, dest, ALU_result, st_val,
        output freeze, wb_en_out, mem_r_en_out, dest_out, ALU_result_out, mem_result
    );
`endif
endinterface

// File: rtl/mem_stage.sv
// Purpose: pipeline memory stage with an internal word-addressed data RAM and the MEM/WB register.
// Latency: non-memory op 1 cycle; load/store WAIT_CYCLES+2 cycles, load data visible after DONE.
// Backpressure: freeze is held high (combinationally) while an access is in flight; upstream holds inputs.
//
// Ports:
//   clk, rst : pipeline clock, synchronous active-high reset
//   bus      : mem_stage_if.slave -- request fields in, freeze and MEM/WB fields out
// Optional feature: define MEM_ERR_CHECK_EN to add alignment/range checking and mem_err_out.
module mem_stage #(
    parameter int          DEPTH_WORDS = 64,
    parameter logic [31:0] BASE_ADDR   = 32'd1024,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    mem_stage_if.slave bus
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [31:0]       rd_buf_q;
    logic [31:0]       mem_q [DEPTH_WORDS];

    // MEM/WB register
    logic              wb_en_q,      wb_en_d;
    logic              mem_r_en_q,   mem_r_en_d;
    logic [4:0]        dest_q,       dest_d;
    logic [31:0]       alu_q,        alu_d;
    logic [31:0]       mem_result_q, mem_result_d;
`ifdef MEM_ERR_CHECK_EN
    logic              mem_err_q,    mem_err_d;
`endif

    // A simultaneous read+write request is treated as a store.
    logic mem_op, is_store, is_load, in_done, last_wait, freeze_w;
    assign mem_op    = bus.mem_r_en | bus.mem_w_en;
    assign is_store  = bus.mem_w_en;
    assign is_load   = bus.mem_r_en & ~bus.mem_w_en;
    assign in_done   = (state_q == S_DONE);
    assign last_wait = (state_q == S_WAIT) && (cnt_q == CNT_LAST);

    // Unsigned subtract; addresses below the base wrap around to high offsets.
    logic [31:0]      offset;
    logic [IDX_W-1:0] word_idx;
    assign offset   = bus.ALU_result - BASE_ADDR;
    assign word_idx = offset[IDX_W+1:2];

    // Only the word-index bits of the offset feed the RAM address.
    logic unused_offset_bits;
    assign unused_offset_bits = ^{offset[31:IDX_W+2], offset[1:0]};

    logic acc_err;
`ifdef MEM_ERR_CHECK_EN
    // Below-base addresses also show up as huge offsets, but both tests are kept for clarity.
    assign acc_err = (|bus.ALU_result[1:0])
                   | (bus.ALU_result < BASE_ADDR)
                   | (offset >= 32'(4 * DEPTH_WORDS));
`else
    assign acc_err = 1'b0;
`endif

    // Stall from the cycle a request is first seen through the last wait state.
    assign freeze_w = !rst && (((state_q == S_IDLE) && mem_op) || (state_q == S_WAIT));

    // Next value of the MEM/WB register: a bubble while frozen, otherwise the
    // current (held) instruction. Outside DONE the stage only sees non-memory ops.
    always_comb begin
        wb_en_d      = 1'b0;
        mem_r_en_d   = 1'b0;
        dest_d       = '0;
        alu_d        = '0;
        mem_result_d = '0;
`ifdef MEM_ERR_CHECK_EN
        mem_err_d    = 1'b0;
`endif
        if (!freeze_w) begin
            wb_en_d      = bus.wb_en & ~(bus.mem_r_en & bus.mem_w_en) & ~(in_done & acc_err);
            mem_r_en_d   = is_load;
            dest_d       = bus.dest;
            alu_d        = bus.ALU_result;
            mem_result_d = (in_done && is_load) ? rd_buf_q : 32'd0;
`ifdef MEM_ERR_CHECK_EN
            mem_err_d    = in_done & acc_err;
`endif
        end
    end

    // Access FSM plus MEM/WB register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            rd_buf_q     <= '0;
            wb_en_q      <= 1'b0;
            mem_r_en_q   <= 1'b0;
            dest_q       <= '0;
            alu_q        <= '0;
            mem_result_q <= '0;
`ifdef MEM_ERR_CHECK_EN
            mem_err_q    <= 1'b0;
`endif
        end else begin
            wb_en_q      <= wb_en_d;
            mem_r_en_q   <= mem_r_en_d;
            dest_q       <= dest_d;
            alu_q        <= alu_d;
            mem_result_q <= mem_result_d;
`ifdef MEM_ERR_CHECK_EN
            mem_err_q    <= mem_err_d;
`endif
            case (state_q)
                S_IDLE: begin
                    if (mem_op) begin
                        cnt_q   <= '0;
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt_q == CNT_LAST) begin
                        if (is_load) begin
                            rd_buf_q <= acc_err ? 32'd0 : mem_q[word_idx];
                        end
                        state_q <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // RAM contents are not reset; a store commits only at the end of the last
    // wait state, so a reset before then drops it.
    always_ff @(posedge clk) begin
        if (!rst && last_wait && is_store && !acc_err) begin
            mem_q[word_idx] <= bus.st_val;
        end
    end

    assign bus.freeze         = freeze_w;
    assign bus.wb_en_out      = wb_en_q;
    assign bus.mem_r_en_out   = mem_r_en_q;
    assign bus.dest_out       = dest_q;
    assign bus.ALU_result_out = alu_q;
    assign bus.mem_result     = mem_result_q;
`ifdef MEM_ERR_CHECK_EN
    assign bus.mem_err_out    = mem_err_q;
`endif

endmodule
